// File: rtl/ex_muldiv_if.sv
// Handshake and data bundle between the E-stage controller/forwarding logic and ex_muldiv.
interface ex_muldiv_if;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_hi;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  modport master (
    output md_op, A, B, rd_hi,
    input  start, busy, HI, LO, md_out
  );

  modport slave (
    input  md_op, A, B, rd_hi,
    output start, busy, HI, LO, md_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and held pending until the fixed latency expires.
module ex_muldiv #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  ex_muldiv_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_ok_q, pend_ok_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  // Multiplier: sign-extend to 64 bits so one unsigned multiply serves both flavours.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_sgn = (bus.md_op == OpMult);
  assign mul_a   = {{32{mul_sgn & bus.A[31]}}, bus.A};
  assign mul_b   = {{32{mul_sgn & bus.B[31]}}, bus.B};
  assign prod    = mul_a * mul_b;

  // Divider on magnitudes; signs restored afterwards so 0x80000000 / -1 wraps cleanly.
  logic        div_sgn;
  logic [31:0] div_a, div_b, div_b_safe, quot_mag, rem_mag, quot, rem;

  assign div_sgn    = (bus.md_op == OpDiv);
  assign div_a      = (div_sgn & bus.A[31]) ? (32'd0 - bus.A) : bus.A;
  assign div_b      = (div_sgn & bus.B[31]) ? (32'd0 - bus.B) : bus.B;
  assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
  assign quot_mag   = div_a / div_b_safe;
  assign rem_mag    = div_a % div_b_safe;
  assign quot       = (div_sgn & (bus.A[31] ^ bus.B[31])) ? (32'd0 - quot_mag) : quot_mag;
  assign rem        = (div_sgn & bus.A[31]) ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        unique case (bus.md_op)
          OpMult, OpMultu: begin
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
            pend_ok_d = 1'b1;
            cnt_d     = MultCnt;
            state_d   = StBusy;
          end
          OpDiv, OpDivu: begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_ok_d = (bus.B != 32'd0);
            cnt_d     = DivCnt;
            state_d   = StBusy;
          end
          OpMthi:  hi_d = bus.A;
          OpMtlo:  lo_d = bus.A;
          default: ;
        endcase
      end
      StBusy: begin
        // Any md_op arriving while busy is dropped, including on the completing edge.
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy   = (state_q == StBusy);
  assign bus.start  = (bus.md_op >= OpMult) && (bus.md_op <= OpDivu) && (state_q == StIdle);
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.md_out = bus.rd_hi ? hi_q : lo_q;

endmodule
